// File: rtl/cl_sd_region_loader_if.sv
// SD byte-stream and indexed word-write bundle between sd_controller, the region loader
// and the metadata/song consumers.
interface cl_sd_region_loader_if #(
  parameter int WORD_BYTES = 4,
  parameter int WADDR_W    = 16
);
  logic                    sd_ready;
  logic                    sd_byte_available;
  logic [7:0]              sd_dout;
  logic                    sd_rd;
  logic [31:0]             sd_address;
  logic                    word_valid;
  logic [8*WORD_BYTES-1:0] word_data;
  logic [WADDR_W-1:0]      word_addr;
  logic                    word_region;

  modport master (
    input  sd_ready, sd_byte_available, sd_dout,
    output sd_rd, sd_address, word_valid, word_data, word_addr, word_region
  );

  modport slave (
    output sd_ready, sd_byte_available, sd_dout,
    input  sd_rd, sd_address, word_valid, word_data, word_addr, word_region
  );
endinterface

// File: rtl/cl_sd_region_loader.sv
// Reads the metadata region and then the song region from sd_controller sector by sector,
// packs bytes into words and emits indexed word writes plus per-region loaded flags.
module cl_sd_region_loader #(
  parameter int          WORD_BYTES     = 4,
  parameter int          BIG_ENDIAN     = 1,
  parameter logic [31:0] DATA_ADR       = 32'h0000_0000,
  parameter int          DATA_SECTORS   = 1,
  parameter logic [31:0] SONG_ADR       = 32'h0001_0000,
  parameter int          SONG_SECTORS   = 0,
  parameter int          WADDR_W        = 16,
  parameter int          TIMEOUT_CYCLES = 25_000_000
) (
  input  logic                          clk25,
  input  logic                          reset,
  input  logic                          start,
  cl_sd_region_loader_if.master         bus,
  output logic                          data_loaded,
  output logic                          song_loaded,
  output logic                          busy,
  output logic                          error
);
  localparam int W = 8 * WORD_BYTES;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WAIT  = 3'd1,
    ISSUE = 3'd2,
    READ  = 3'd3,
    NEXT  = 3'd4,
    ERROR = 3'd5
  } state_t;

  state_t             state_r;
  logic               bav_d_r;
  logic               region_r;
  logic [31:0]        sector_r;
  logic [8:0]         byte_cnt_r;
  logic [W-1:0]       shift_r;
  logic [WADDR_W-1:0] word_cnt_r;
  logic [31:0]        tmo_r;
  logic               sd_rd_r;
  logic [31:0]        sd_address_r;
  logic               word_valid_r;
  logic [W-1:0]       word_data_r;
  logic [WADDR_W-1:0] word_addr_r;
  logic               word_region_r;

  logic               edge_s;
  logic               word_done_s;
  logic               tmo_hit_s;
  logic               sector_last_s;
  logic [31:0]        addr_s;
  logic [W-1:0]       shift_next_s;

  function automatic logic [W-1:0] shift_in(input logic [W-1:0] acc, input logic [7:0] b);
    if (BIG_ENDIAN != 0) shift_in = (acc << 8) | W'(b);
    else                 shift_in = (acc >> 8) | (W'(b) << (W - 8));
  endfunction

  assign edge_s        = bus.sd_byte_available & ~bav_d_r;
  assign word_done_s   = ((byte_cnt_r & 9'(WORD_BYTES - 1)) == 9'(WORD_BYTES - 1));
  assign tmo_hit_s     = (tmo_r == 32'(TIMEOUT_CYCLES - 1));
  assign sector_last_s = ((sector_r + 32'd1) == (region_r ? 32'(SONG_SECTORS) : 32'(DATA_SECTORS)));
  assign addr_s        = (region_r ? SONG_ADR : DATA_ADR) + (sector_r << 9);
  assign shift_next_s  = shift_in(shift_r, bus.sd_dout);

  assign bus.sd_rd       = sd_rd_r;
  assign bus.sd_address  = sd_address_r;
  assign bus.word_valid  = word_valid_r;
  assign bus.word_data   = word_data_r;
  assign bus.word_addr   = word_addr_r;
  assign bus.word_region = word_region_r;

  // Load sequencer: sector requests, byte packing, word strobes, flags and stall timeout.
  always_ff @(posedge clk25 or posedge reset) begin
    if (reset) begin
      state_r       <= IDLE;
      bav_d_r       <= 1'b0;
      region_r      <= 1'b0;
      sector_r      <= 32'd0;
      byte_cnt_r    <= 9'd0;
      shift_r       <= '0;
      word_cnt_r    <= '0;
      tmo_r         <= 32'd0;
      sd_rd_r       <= 1'b0;
      sd_address_r  <= DATA_ADR;
      word_valid_r  <= 1'b0;
      word_data_r   <= '0;
      word_addr_r   <= '0;
      word_region_r <= 1'b0;
      data_loaded   <= 1'b0;
      song_loaded   <= 1'b0;
      busy          <= 1'b0;
      error         <= 1'b0;
    end else begin
      bav_d_r      <= bus.sd_byte_available;
      word_valid_r <= 1'b0;
      case (state_r)
        IDLE, ERROR: begin
          if (start) begin
            state_r     <= WAIT;
            busy        <= 1'b1;
            data_loaded <= 1'b0;
            song_loaded <= 1'b0;
            error       <= 1'b0;
            region_r    <= 1'b0;
            sector_r    <= 32'd0;
            byte_cnt_r  <= 9'd0;
            word_cnt_r  <= '0;
            tmo_r       <= 32'd0;
          end
        end
        WAIT: begin
          if (bus.sd_ready) begin
            state_r      <= ISSUE;
            sd_rd_r      <= 1'b1;
            sd_address_r <= addr_s;
            tmo_r        <= 32'd0;
          end else if (tmo_hit_s) begin
            state_r <= ERROR;
            busy    <= 1'b0;
            error   <= 1'b1;
            sd_rd_r <= 1'b0;
          end else begin
            tmo_r <= tmo_r + 32'd1;
          end
        end
        ISSUE: begin
          if (!bus.sd_ready) begin
            state_r <= READ;
            sd_rd_r <= 1'b0;
            tmo_r   <= 32'd0;
          end else if (tmo_hit_s) begin
            state_r <= ERROR;
            busy    <= 1'b0;
            error   <= 1'b1;
            sd_rd_r <= 1'b0;
          end else begin
            tmo_r <= tmo_r + 32'd1;
          end
        end
        READ: begin
          if (edge_s) begin
            shift_r    <= shift_next_s;
            byte_cnt_r <= byte_cnt_r + 9'd1;
            tmo_r      <= 32'd0;
            if (word_done_s) begin
              word_valid_r  <= 1'b1;
              word_data_r   <= shift_next_s;
              word_addr_r   <= word_cnt_r;
              word_region_r <= region_r;
              word_cnt_r    <= word_cnt_r + 1'b1;
            end
            if (byte_cnt_r == 9'd511) state_r <= NEXT;
          end else if (tmo_hit_s) begin
            state_r <= ERROR;
            busy    <= 1'b0;
            error   <= 1'b1;
            sd_rd_r <= 1'b0;
          end else begin
            tmo_r <= tmo_r + 32'd1;
          end
        end
        NEXT: begin
          sector_r <= sector_r + 32'd1;
          tmo_r    <= 32'd0;
          if (!sector_last_s) begin
            state_r <= WAIT;
          end else if (!region_r && (SONG_SECTORS > 0)) begin
            data_loaded <= 1'b1;
            region_r    <= 1'b1;
            sector_r    <= 32'd0;
            word_cnt_r  <= '0;
            word_addr_r <= '0;
            state_r     <= WAIT;
          end else begin
            // Either region 1 finished, or region 0 finished with no song region.
            data_loaded <= 1'b1;
            song_loaded <= 1'b1;
            busy        <= 1'b0;
            state_r     <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          sd_rd_r <= 1'b0;
        end
      endcase
    end
  end
endmodule
